// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: shares the 8-bit uio pad bus between N_REQ requesters with a registered
// pad drive, hold watchdog and one-cycle turnaround. UIO_ARB_FIXED_PRIO_EN selects fixed priority.
//
// state   | meaning
// S_IDLE  | pads released, arbitrating among pending requests when ena=1
// S_GRANT | one requester owns the bus, its data/enables are registered onto the pads
// S_TURN  | single undriven cycle between owners
module uio_bus_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255,
    parameter int TW      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   done,
    input  logic [8*N_REQ-1:0] req_dout,
    input  logic [8*N_REQ-1:0] req_oe,
    input  logic [7:0]         uio_in,
    output logic [7:0]         uio_out,
    output logic [7:0]         uio_oe,
    output logic [N_REQ-1:0]   gnt,
    output logic [7:0]         rd_data,
    output logic               timeout_err,
    input  logic               err_clr
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [TW-1:0] WDOG_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_TURN
    } state_t;

    state_t           state, state_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [IW-1:0]    last, last_nxt;
    logic [TW-1:0]    wdog, wdog_nxt;
    logic [7:0]       out_nxt, oe_nxt;
    logic             err_nxt;
    logic             win_found;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    cand;
    logic [7:0]       dout_sel, oe_sel;
    logic             own_rel, wdog_hit;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
`ifdef UIO_ARB_FIXED_PRIO_EN
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[IW'(i)]) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
            end
        end
`else
        // Scan offsets high to low so the requester nearest after last is the final write.
        for (int off = N_REQ; off >= 1; off--) begin
            cand = IW'((int'(last) + off) % N_REQ);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
`endif
    end

    always_comb begin
        dout_sel = '0;
        oe_sel   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (last == IW'(i)) begin
                dout_sel = req_dout[8*i +: 8];
                oe_sel   = req_oe[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        last_nxt  = last;
        wdog_nxt  = wdog;
        out_nxt   = uio_out;
        oe_nxt    = uio_oe;
        err_nxt   = timeout_err;
        own_rel   = done[last] | ~req[last];
        wdog_hit  = (wdog == WDOG_LAST);

        if (err_clr) begin
            err_nxt = 1'b0;
        end

        case (state)
            S_IDLE: begin
                gnt_nxt = '0;
                out_nxt = '0;
                oe_nxt  = '0;
                if (ena && win_found) begin
                    state_nxt         = S_GRANT;
                    gnt_nxt[win_idx]  = 1'b1;
                    last_nxt          = win_idx;
                    wdog_nxt          = '0;
                end
            end
            S_GRANT: begin
                wdog_nxt = wdog + 1'b1;
                if (own_rel || !ena || wdog_hit) begin
                    state_nxt = S_TURN;
                    gnt_nxt   = '0;
                    out_nxt   = '0;
                    oe_nxt    = '0;
                    // An owner release in the same cycle as the watchdog is a normal release.
                    if (wdog_hit && !own_rel) begin
                        err_nxt = 1'b1;
                    end
                end else begin
                    out_nxt = dout_sel;
                    oe_nxt  = oe_sel;
                end
            end
            S_TURN: begin
                state_nxt = S_IDLE;
                gnt_nxt   = '0;
                out_nxt   = '0;
                oe_nxt    = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                gnt_nxt   = '0;
                out_nxt   = '0;
                oe_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            gnt         <= '0;
            last        <= IW'(N_REQ - 1);
            wdog        <= '0;
            uio_out     <= '0;
            uio_oe      <= '0;
            timeout_err <= 1'b0;
            rd_data     <= '0;
        end else begin
            state       <= state_nxt;
            gnt         <= gnt_nxt;
            last        <= last_nxt;
            wdog        <= wdog_nxt;
            uio_out     <= out_nxt;
            uio_oe      <= oe_nxt;
            timeout_err <= err_nxt;
            rd_data     <= uio_in;
        end
    end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Bench for uio_bus_arbiter: directed scenarios plus random traffic, checked per cycle
// against a hold-count / free-time reference model through a scoreboard queue.
module tb_uio_bus_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    logic           clk      = 1'b0;
    logic           rst_n    = 1'b1;
    logic           ena      = 1'b0;
    logic           err_clr  = 1'b0;
    logic [N-1:0]   req      = '0;
    logic [N-1:0]   done     = '0;
    logic [8*N-1:0] req_dout = '0;
    logic [8*N-1:0] req_oe   = '0;
    logic [7:0]     uio_in   = '0;
    logic [7:0]     uio_out, uio_oe, rd_data;
    logic [N-1:0]   gnt;
    logic           timeout_err;

    uio_bus_arbiter #(.N_REQ(N), .TIMEOUT(TO), .TW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .req        (req),
        .done       (done),
        .req_dout   (req_dout),
        .req_oe     (req_oe),
        .uio_in     (uio_in),
        .uio_out    (uio_out),
        .uio_oe     (uio_oe),
        .gnt        (gnt),
        .rd_data    (rd_data),
        .timeout_err(timeout_err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [7:0]   out;
        logic [7:0]   oe;
        logic [7:0]   rd;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    int   gnt_log[$];

    // Reference model: an owner index, how many grant cycles it has held, and the
    // first edge at which a new grant may be issued after a release.
    int   m_owner   = -1;
    int   m_last    = N - 1;
    int   m_held    = 0;
    int   m_free_at = 0;
    int   m_cyc     = 0;
    bit   m_err     = 1'b0;
    bit   m_rel, m_wd, m_leave;
    exp_t m_e;

    function automatic int pick(input logic [N-1:0] r, input int last_w);
`ifdef UIO_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (r[(last_w + k) % N]) return (last_w + k) % N;
`endif
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_owner   = -1;
            m_last    = N - 1;
            m_held    = 0;
            m_free_at = 0;
            m_cyc     = 0;
            m_err     = 1'b0;
        end else begin
            m_e    = '0;
            m_e.rd = uio_in;
            m_wd   = 1'b0;
            if (m_owner >= 0) begin
                m_held++;
                m_rel   = done[m_owner] || !req[m_owner];
                m_leave = m_rel || !ena || (m_held == TO);
                m_wd    = (m_held == TO) && !m_rel;
                if (m_leave) begin
                    m_owner   = -1;
                    m_free_at = m_cyc + 2;
                end else begin
                    m_e.out = req_dout[8*m_owner +: 8];
                    m_e.oe  = req_oe[8*m_owner +: 8];
                end
            end else if (m_cyc >= m_free_at && ena && req != '0) begin
                m_owner = pick(req, m_last);
                m_last  = m_owner;
                m_held  = 0;
            end
            if (err_clr) m_err = 1'b0;
            if (m_wd) m_err = 1'b1;
            if (m_owner >= 0) m_e.gnt[m_owner] = 1'b1;
            m_e.err = m_err;
            exp_q.push_back(m_e);
            m_cyc++;
        end
    end

    exp_t         mon_e;
    logic [N-1:0] prev_gnt = '0;
    int           mon_idx;

    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("sb_gnt", 32'(gnt), 32'(mon_e.gnt));
                chk("sb_uio_out", 32'(uio_out), 32'(mon_e.out));
                chk("sb_uio_oe", 32'(uio_oe), 32'(mon_e.oe));
                chk("sb_rd_data", 32'(rd_data), 32'(mon_e.rd));
                chk("sb_timeout_err", 32'(timeout_err), 32'(mon_e.err));
            end
            if (gnt != '0 && prev_gnt == '0) begin
                mon_idx = -1;
                for (int i = 0; i < N; i++) if (gnt[i]) mon_idx = i;
                gnt_log.push_back(mon_idx);
            end
        end
        prev_gnt = gnt;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wd_run(input bit with_done, output int cnt);
        cnt = 0;
        req = 4'b0100;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (gnt[2]) begin
                cnt++;
                done = (with_done && cnt == TO) ? 4'b0100 : 4'b0000;
            end else if (cnt > 0) begin
                break;
            end
        end
        req  = '0;
        done = '0;
    endtask

    int exp_order[5];
    int hc, wcnt, w;

    initial begin
`ifdef UIO_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        #1 rst_n = 1'b0;
        #2;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_uio_oe", 32'(uio_oe), 0);
        chk("rst_uio_out", 32'(uio_out), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        ena    = 1'b1;
        uio_in = 8'h3C;
        tick();
        chk("readback_rd_data", 32'(rd_data), 32'h3C);
        chk("readback_no_gnt", 32'(gnt), 0);

        // single owner with done on its 4th grant cycle
        req_dout[15:8] = 8'hA5;
        req_oe[15:8]   = 8'hFF;
        req            = 4'b0010;
        tick();
        chk("single_gnt", 32'(gnt), 32'b0010);
        chk("single_oe_lag", 32'(uio_oe), 0);
        tick();
        chk("single_oe", 32'(uio_oe), 32'hFF);
        chk("single_out", 32'(uio_out), 32'hA5);
        tick();
        tick();
        done = 4'b0010;
        tick();
        chk("single_turn_gnt", 32'(gnt), 0);
        chk("single_turn_oe", 32'(uio_oe), 0);
        done = '0;
        req  = '0;
        tick();

        // asynchronous reset while driving the pads
        req_dout[7:0] = 8'h5A;
        req_oe[7:0]   = 8'hFF;
        req           = 4'b0001;
        tick();
        tick();
        chk("midrst_pre_oe", 32'(uio_oe), 32'hFF);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_oe", 32'(uio_oe), 0);
        chk("midrst_gnt", 32'(gnt), 0);
        chk("midrst_out", 32'(uio_out), 0);
        req = '0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        chk("midrst_idle_gnt", 32'(gnt), 0);
        tick();

        // arbitration order with all four requesting
        gnt_log.delete();
        req = 4'b1111;
        hc  = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (gnt != '0) begin
                hc++;
                done = (hc == 2) ? gnt : '0;
            end else begin
                hc   = 0;
                done = '0;
            end
            if (gnt_log.size() >= 5) break;
        end
        req  = '0;
        done = '0;
        chk("rr_count", 32'(gnt_log.size() >= 5), 1);
        for (int i = 0; i < 5; i++) begin
            if (i < gnt_log.size()) chk("rr_order", 32'(gnt_log[i]), 32'(exp_order[i]));
        end
        repeat (4) tick();

        // watchdog
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("wd_pre_err", 32'(timeout_err), 0);
        wd_run(1'b0, wcnt);
        chk("wd_hold_cycles", 32'(wcnt), 32'(TO));
        chk("wd_err_set", 32'(timeout_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("wd_err_clr", 32'(timeout_err), 0);
        tick();
        wd_run(1'b1, wcnt);
        chk("wd_done_cycles", 32'(wcnt), 32'(TO));
        chk("wd_done_no_err", 32'(timeout_err), 0);
        repeat (3) tick();

        // enable drop during a grant
        req = 4'b0100;
        w   = 0;
        while (!gnt[2] && w < 10) begin
            tick();
            w++;
        end
        chk("ena_first_grant", 32'(gnt[2]), 1);
        tick();
        ena = 1'b0;
        tick();
        chk("ena_drop_release", 32'(gnt), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ena_low_hold", 32'(gnt), 0);
        end
        ena = 1'b1;
        tick();
        chk("ena_return_grant", 32'(gnt), 32'b0100);
        req = '0;
        repeat (4) tick();

        // random traffic, checked by the scoreboard
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #2;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(7) == 0) req[b] = ~req[b];
                done[b] = ($urandom_range(4) == 0);
            end
            ena      = ($urandom_range(19) != 0);
            err_clr  = ($urandom_range(9) == 0);
            req_dout = $urandom;
            req_oe   = $urandom;
            uio_in   = 8'($urandom_range(255));
        end
        req     = '0;
        done    = '0;
        err_clr = 1'b0;
        repeat (5) tick();
        chk("sb_drained", 32'(exp_q.size() <= 1), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, got %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule
